// File: rtl/l0_rd_scheduler_pkg.sv
// l0_pkg: shared definitions for the L0 input-buffer read path.
//   ROW / LEN_BW : default row count and burst-length width, shared with the
//                  L0 FIFO bank.
//   mode_e       : command mode (MODE_ALL = all rows together,
//                  MODE_SKEW = diagonal wavefront).
//   state_e      : read scheduler FSM states.
package l0_pkg;

    localparam int unsigned ROW    = 8;
    localparam int unsigned LEN_BW = 7;

    typedef enum logic {
        MODE_ALL  = 1'b0,
        MODE_SKEW = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/l0_rd_scheduler_if.sv
// l0_rd_scheduler_if: command / FIFO-status / read-enable bundle of the L0
// read scheduler.
//   start, mode, len : command strobe, mode and words per row
//   i_empty          : per-row empty flags from the L0 FIFOs
//   stall            : downstream backpressure
//   rd_en            : per-row FIFO read enables
//   busy, done       : command in progress / one-cycle completion pulse
// master = command issuer / FIFO side, slave = the scheduler.
interface l0_rd_scheduler_if
    import l0_pkg::*;
#(
    parameter int unsigned row    = ROW,
    parameter int unsigned len_bw = LEN_BW
);

    logic              start;
    logic              mode;
    logic [len_bw-1:0] len;
    logic [row-1:0]    i_empty;
    logic              stall;
    logic [row-1:0]    rd_en;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, len, i_empty, stall,
        input  rd_en, busy, done
    );

    modport slave (
        input  start, mode, len, i_empty, stall,
        output rd_en, busy, done
    );

endinterface

// File: rtl/l0_rd_scheduler_window.sv
// l0_rd_window: combinational row window mask for step t.
//   t    : schedule step counter (len_bw+1 bits)
//   mode : captured command mode
//   len  : captured words per row
//   win  : win[i]=1 when row i reads at step t
//          MODE_ALL : t < len
//          MODE_SKEW: i <= t < i + len
module l0_rd_window
    import l0_pkg::*;
#(
    parameter int unsigned row    = ROW,
    parameter int unsigned len_bw = LEN_BW
) (
    input  logic [len_bw:0]   t,
    input  mode_e             mode,
    input  logic [len_bw-1:0] len,
    output logic [row-1:0]    win
);

    // One extra bit so that i + len cannot wrap for any legal row count.
    typedef logic [len_bw+1:0] wide_t;

    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < row; i++) begin
            if (mode == MODE_ALL) begin
                win[i] = (wide_t'(t) < wide_t'(len));
            end else begin
                win[i] = (wide_t'(t) >= wide_t'(i)) &&
                         (wide_t'(t) <  wide_t'(i) + wide_t'(len));
            end
        end
    end

endmodule

// File: rtl/l0_rd_scheduler.sv
// l0_rd_scheduler: sequences the read enables of the L0 row FIFOs that feed
// the west edge of the systolic array. One command reads len words from
// every row, either all rows together or as a diagonal wavefront.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : l0_rd_scheduler_if slave (start/mode/len/i_empty/stall in,
//           rd_en/busy/done out)
module l0_rd_scheduler
    import l0_pkg::*;
#(
    parameter int unsigned row    = ROW,
    parameter int unsigned len_bw = LEN_BW
) (
    input logic                 clk,
    input logic                 reset,
    l0_rd_scheduler_if.slave    bus
);

    typedef logic [len_bw:0]   step_t;
    typedef logic [len_bw+1:0] wide_t;

    state_e            state, state_nx;
    step_t             t, t_nx;
    mode_e             mode_q, mode_nx;
    logic [len_bw-1:0] len_q, len_nx;
    logic              done_q, done_nx;

    logic [row-1:0]    win;
    wide_t             last_t;
    logic              last_step;
    logic              adv;

    l0_rd_window #(
        .row    (row),
        .len_bw (len_bw)
    ) u_window (
        .t    (t),
        .mode (mode_q),
        .len  (len_q),
        .win  (win)
    );

    // Last step index N-1; len_q is never zero while in RUN.
    always_comb begin
        last_t = wide_t'(len_q) - wide_t'(1);
        if (mode_q == MODE_SKEW) begin
            last_t = last_t + wide_t'(row - 1);
        end
    end
    assign last_step = (wide_t'(t) == last_t);

    // The whole wavefront advances or none of it does, so the skew between
    // rows is preserved across stalls and empty rows.
    assign adv = (state == RUN) && !bus.stall && ((win & bus.i_empty) == '0);

    assign bus.rd_en = win & {row{adv}};
    assign bus.busy  = (state == RUN);
    assign bus.done  = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            t      <= '0;
            mode_q <= MODE_ALL;
            len_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            t      <= t_nx;
            mode_q <= mode_nx;
            len_q  <= len_nx;
            done_q <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        t_nx     = t;
        mode_nx  = mode_q;
        len_nx   = len_q;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        mode_nx  = mode_e'(bus.mode);
                        len_nx   = bus.len;
                        t_nx     = '0;
                        state_nx = RUN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (adv) begin
                    if (last_step) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        t_nx = t + step_t'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l0_rd_scheduler.sv
// tb_l0_rd_scheduler: directed bench for l0_rd_scheduler (row=8, len_bw=7).
// Each cycle's expected rd_en/busy/done is queued as the stimulus is driven
// and popped and compared at the following falling clock edge.
module tb_l0_rd_scheduler;

    typedef struct {
        logic [7:0] rd_en;
        logic       busy;
        logic       done;
    } exp_t;

    logic  clk;
    logic  rst_n;
    int    checks;
    int    failures;
    string tag;
    exp_t  sb[$];

    logic [7:0] skew3 [10];

    l0_rd_scheduler_if #(.row(8), .len_bw(7)) bus ();

    l0_rd_scheduler #(.row(8), .len_bw(7)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input int cyc_no);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty at cycle %0d", tag, cyc_no);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (bus.rd_en === e.rd_en) else begin
                failures++;
                $error("FAIL %s c%0d rd_en got=%h want=%h", tag, cyc_no, bus.rd_en, e.rd_en);
            end
            checks++;
            assert (bus.busy === e.busy) else begin
                failures++;
                $error("FAIL %s c%0d busy got=%b want=%b", tag, cyc_no, bus.busy, e.busy);
            end
            checks++;
            assert (bus.done === e.done) else begin
                failures++;
                $error("FAIL %s c%0d done got=%b want=%b", tag, cyc_no, bus.done, e.done);
            end
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, compare at negedge,
    // then advance to just after the next rising edge.
    int cyc_cnt;
    task automatic cyc(input logic s, input logic m, input logic [6:0] l,
                       input logic [7:0] emp, input logic st,
                       input logic [7:0] e_rd, input logic e_busy, input logic e_done);
        exp_t e;
        bus.start   = s;
        bus.mode    = m;
        bus.len     = l;
        bus.i_empty = emp;
        bus.stall   = st;
        e.rd_en = e_rd;
        e.busy  = e_busy;
        e.done  = e_done;
        sb.push_back(e);
        @(negedge clk);
        check_out(cyc_cnt);
        cyc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [7:0] e_rd, input logic e_busy, input logic e_done);
        cyc(1'b0, 1'b0, 7'd0, 8'h00, 1'b0, e_rd, e_busy, e_done);
    endtask

    task automatic skew_steps(input int from, input int to);
        for (int k = from; k <= to; k++) idle(skew3[k], 1'b1, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc_cnt  = 0;
        skew3 = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC0, 8'h80};

        // Reset state
        tag   = "reset";
        rst_n = 1'b0;
        idle(8'h00, 1'b0, 1'b0);
        idle(8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(8'h00, 1'b0, 1'b0);

        // MODE_ALL len=4, with an ignored start while busy
        tag = "all_len4";
        cyc(1'b1, 1'b0, 7'd4, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(8'hFF, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 7'd7, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
        idle(8'hFF, 1'b1, 1'b0);
        idle(8'hFF, 1'b1, 1'b0);
        // Done cycle doubles as the start cycle of the next command
        cyc(1'b1, 1'b1, 7'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

        // MODE_SKEW len=3
        tag = "skew_len3";
        skew_steps(0, 9);
        idle(8'h00, 1'b0, 1'b1);
        idle(8'h00, 1'b0, 1'b0);

        // Stall two cycles at mask 1C
        tag = "skew_stall";
        cyc(1'b1, 1'b1, 7'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        skew_steps(0, 3);
        cyc(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 7'd0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        skew_steps(4, 9);
        idle(8'h00, 1'b0, 1'b1);
        idle(8'h00, 1'b0, 1'b0);

        // Row 3 empty while mask is 0E holds the whole wavefront
        tag = "skew_empty3";
        cyc(1'b1, 1'b1, 7'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        skew_steps(0, 2);
        cyc(1'b0, 1'b0, 7'd0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 7'd0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0);
        skew_steps(3, 9);
        idle(8'h00, 1'b0, 1'b1);

        // Row 7 empty while outside the window has no effect
        tag = "skew_empty7";
        cyc(1'b1, 1'b1, 7'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        skew_steps(0, 2);
        cyc(1'b0, 1'b0, 7'd0, 8'h80, 1'b0, 8'h0E, 1'b1, 1'b0);
        skew_steps(4, 9);
        idle(8'h00, 1'b0, 1'b1);
        idle(8'h00, 1'b0, 1'b0);

        // len=0: no reads, done next cycle, never busy
        tag = "len0";
        cyc(1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(8'h00, 1'b0, 1'b1);
        idle(8'h00, 1'b0, 1'b0);

        // Reset mid-command: outputs drop immediately, no done afterwards
        tag = "reset_mid";
        cyc(1'b1, 1'b1, 7'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        skew_steps(0, 1);
        rst_n = 1'b0;
        idle(8'h00, 1'b0, 1'b0);
        idle(8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(8'h00, 1'b0, 1'b0);
        idle(8'h00, 1'b0, 1'b0);
        tag = "after_reset";
        cyc(1'b1, 1'b0, 7'd2, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(8'hFF, 1'b1, 1'b0);
        idle(8'hFF, 1'b1, 1'b0);
        idle(8'h00, 1'b0, 1'b1);
        idle(8'h00, 1'b0, 1'b0);

        tag = "final";
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL %s scoreboard leftover got=%0d want=0", tag, sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
